// File: rtl/hilo_muldiv_unit.sv
// HI/LO owning multiply/divide engine.
// Iterative shift-add multiply, restoring divide, mthi/mtlo writes.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_MULU = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_q, mul_d;
  logic             dz_q, dz_d;
  logic             nlo_q, nlo_d;
  logic             nhi_q, nhi_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic op_mul, op_div, op_sgn;
  logic op_mthi, op_mtlo;
  logic b_zero, dz_req, run_req;
  logic a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign op_mul  = (op == OP_MUL) || (op == OP_MULU);
  assign op_div  = (op == OP_DIV) || (op == OP_DIVU);
  assign op_sgn  = (op == OP_MUL) || (op == OP_DIV);
  assign op_mthi = (op == OP_MTHI);
  assign op_mtlo = (op == OP_MTLO);
  assign b_zero  = (b == '0);
  assign dz_req  = op_div && b_zero;
  assign run_req = op_mul || (op_div && !b_zero);

  assign a_neg = op_sgn && a[WIDTH-1];
  assign b_neg = op_sgn && b[WIDTH-1];
  assign a_abs = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_abs = b_neg ? (~b + WIDTH'(1)) : b;

  assign done        = done_q;
  assign div_by_zero = dbz_q;

  // State and datapath registers with synchronous clear
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      dz_q    <= 1'b0;
      nlo_q   <= 1'b0;
      nhi_q   <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      dz_q    <= dz_d;
      nlo_q   <= nlo_d;
      nhi_q   <= nhi_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state: accept in IDLE, iterate in RUN, one fix-up edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && dz_req) begin
          state_d = S_FIX;
        end else if (start && run_req) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output: busy whenever an operation is in flight
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Datapath: operand latch, one iteration per RUN edge, sign fix-up
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    dz_d    = dz_q;
    nlo_d   = nlo_q;
    nhi_d   = nhi_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    mul_add = quo_q[0] ? opb_q : {WIDTH{1'b0}};
    mul_sum = {1'b0, acc_q} + {1'b0, mul_add};
    shifted = {acc_q, quo_q[WIDTH-1]};
    trial   = shifted[WIDTH-1:0] - opb_q;
    prod    = {acc_q, quo_q};
    q_fix   = quo_q;
    r_fix   = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            op_mthi: begin
              hi_d   = a;
              done_d = 1'b1;
            end
            op_mtlo: begin
              lo_d   = a;
              done_d = 1'b1;
            end
            dz_req: begin
              quo_d = a;
              dz_d  = 1'b1;
              mul_d = 1'b0;
            end
            run_req: begin
              acc_d = '0;
              quo_d = a_abs;
              opb_d = b_abs;
              cnt_d = CNT_W'(WIDTH);
              mul_d = op_mul;
              dz_d  = 1'b0;
              nlo_d = a_neg ^ b_neg;
              nhi_d = a_neg;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (mul_q) begin
          acc_d = mul_sum[WIDTH:1];
          quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        end else if (shifted >= {1'b0, opb_q}) begin
          acc_d = trial;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
      S_FIX: begin
        done_d = 1'b1;
        if (dz_q) begin
          hi_d  = quo_q;
          lo_d  = DIV0_LO;
          dbz_d = 1'b1;
        end else if (mul_q) begin
          if (nlo_q) begin
            prod = ~prod + (2*WIDTH)'(1);
          end
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else begin
          if (nlo_q) begin
            q_fix = ~quo_q + WIDTH'(1);
          end
          if (nhi_q) begin
            r_fix = ~acc_q + WIDTH'(1);
          end
          hi_d = r_fix;
          lo_d = q_fix;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit.
// Drives a 32-bit and an 8-bit instance through hand-computed vectors.
module tb_hilo_muldiv_unit;

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_MULU = 3'b001;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [2:0] OP_RSV  = 3'b110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear;

  logic        s32;
  logic [2:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;

  logic        s8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int total = 0;
  int bad   = 0;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) u32 (
    .clock       (clk),
    .clear       (clear),
    .start       (s32),
    .op          (op32),
    .a           (a32),
    .b           (b32),
    .busy        (busy32),
    .done        (done32),
    .div_by_zero (dz32),
    .hi_q        (hi32),
    .lo_q        (lo32)
  );

  hilo_muldiv_unit #(.WIDTH(8), .CNT_W(4)) u8 (
    .clock       (clk),
    .clear       (clear),
    .start       (s8),
    .op          (op8),
    .a           (a8),
    .b           (b8),
    .busy        (busy8),
    .done        (done8),
    .div_by_zero (dz8),
    .hi_q        (hi8),
    .lo_q        (lo8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic [2:0] o,
                       input logic [31:0] av, input logic [31:0] bv,
                       input bit st);
    if (w8) begin
      s8 = st; op8 = o; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      s32 = st; op32 = o; a32 = av; b32 = bv;
    end
  endtask

  function automatic logic o_done(input bit w8);
    return w8 ? done8 : done32;
  endfunction

  function automatic logic o_busy(input bit w8);
    return w8 ? busy8 : busy32;
  endfunction

  function automatic logic [31:0] o_hi(input bit w8);
    return w8 ? {24'h0, hi8} : hi32;
  endfunction

  function automatic logic [31:0] o_lo(input bit w8);
    return w8 ? {24'h0, lo8} : lo32;
  endfunction

  // One operation: accept, scramble inputs, wait for done, check all.
  task automatic run(input bit w8, input logic [2:0] o,
                     input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] eh, input logic [31:0] el,
                     input bit edz, input int lat, input string tag);
    int k;
    int bc;
    @(negedge clk);
    drive(w8, o, av, bv, 1'b1);
    @(posedge clk);
    #1;
    drive(w8, OP_MTHI, ~av, ~bv, 1'b0);
    k  = 0;
    bc = 0;
    while (!o_done(w8) && k < 100) begin
      if (o_busy(w8)) bc++;
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, ".latency"}, 64'(k), 64'(lat));
    chk({tag, ".busy_cycles"}, 64'(bc), 64'(lat));
    chk({tag, ".hi"}, 64'(o_hi(w8)), 64'(eh));
    chk({tag, ".lo"}, 64'(o_lo(w8)), 64'(el));
    chk({tag, ".dz"}, 64'(w8 ? dz8 : dz32), 64'(edz));
    chk({tag, ".busy_at_done"}, 64'(o_busy(w8)), 64'(0));
    @(posedge clk);
    #1;
    chk({tag, ".done_1cyc"}, 64'(o_done(w8)), 64'(0));
  endtask

  initial begin
    int dcnt;
    clear = 1'b1;
    drive(1'b0, OP_MUL, 32'h0, 32'h0, 1'b0);
    drive(1'b1, OP_MUL, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    chk("rst.hi32", 64'(hi32), 64'(0));
    chk("rst.lo32", 64'(lo32), 64'(0));
    chk("rst.busy32", 64'(busy32), 64'(0));
    chk("rst.done32", 64'(done32), 64'(0));
    chk("rst.dz32", 64'(dz32), 64'(0));
    chk("rst.hi8", 64'(hi8), 64'(0));
    chk("rst.lo8", 64'(lo8), 64'(0));
    chk("rst.busy8", 64'(busy8), 64'(0));

    run(0, OP_MUL,  32'd7, 32'hFFFFFFFD,
        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33, "mul_7_m3");
    run(0, OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 32'h00000001, 0, 33, "mulu_max");
    run(0, OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF,
        32'h0, 32'h1, 0, 33, "mul_m1_m1");
    run(0, OP_DIV,  32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33, "div_m7_2");
    run(0, OP_DIV,  32'd7, 32'hFFFFFFFE,
        32'h1, 32'hFFFFFFFD, 0, 33, "div_7_m2");
    run(0, OP_DIV,  32'h80000000, 32'hFFFFFFFF,
        32'h0, 32'h80000000, 0, 33, "div_min_m1");
    run(0, OP_DIVU, 32'd100, 32'd7,
        32'd2, 32'd14, 0, 33, "divu_100_7");
    run(0, OP_DIV,  32'd5, 32'd0,
        32'd5, 32'hFFFFFFFF, 1, 1, "div0");
    run(0, OP_DIVU, 32'd9, 32'd3,
        32'd0, 32'd3, 0, 33, "divu_9_3");
    run(0, OP_MTHI, 32'h12345678, 32'h0,
        32'h12345678, 32'd3, 0, 0, "mthi");
    run(0, OP_MTLO, 32'hCAFEF00D, 32'h0,
        32'h12345678, 32'hCAFEF00D, 0, 0, "mtlo");

    @(negedge clk);
    drive(0, OP_RSV, 32'h1, 32'h1, 1'b1);
    @(posedge clk);
    #1;
    drive(0, OP_MUL, 32'h0, 32'h0, 1'b0);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (done32 || busy32) dcnt++;
      @(posedge clk);
      #1;
    end
    chk("rsv.activity", 64'(dcnt), 64'(0));
    chk("rsv.hi", 64'(hi32), 64'(32'h12345678));
    chk("rsv.lo", 64'(lo32), 64'(32'hCAFEF00D));

    @(negedge clk);
    drive(0, OP_MUL, 32'd3, 32'd5, 1'b1);
    @(posedge clk);
    #1;
    dcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done32) begin
        dcnt++;
        s32 = 1'b0;
      end
    end
    chk("held.dones", 64'(dcnt), 64'(1));
    chk("held.hi", 64'(hi32), 64'(0));
    chk("held.lo", 64'(lo32), 64'(15));

    run(0, OP_MTHI, 32'h0000ABCD, 32'h0,
        32'h0000ABCD, 32'd15, 0, 0, "mthi2");
    @(negedge clk);
    drive(0, OP_MUL, 32'd3, 32'd5, 1'b1);
    @(posedge clk);
    #1;
    s32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr.hi", 64'(hi32), 64'(0));
    chk("clr.lo", 64'(lo32), 64'(0));
    chk("clr.busy", 64'(busy32), 64'(0));
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32) dcnt++;
      @(posedge clk);
      #1;
    end
    chk("clr.no_done", 64'(dcnt), 64'(0));

    run(1, OP_MUL,  32'd7, 32'hFD, 32'hFF, 32'hEB, 0, 9, "w8.mul");
    run(1, OP_MULU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 0, 9, "w8.mulu");
    run(1, OP_MUL,  32'hFF, 32'hFF, 32'h00, 32'h01, 0, 9, "w8.mul_m1");
    run(1, OP_DIV,  32'hF9, 32'd2, 32'hFF, 32'hFD, 0, 9, "w8.div");
    run(1, OP_DIV,  32'h80, 32'hFF, 32'h00, 32'h80, 0, 9, "w8.div_min");
    run(1, OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 9, "w8.divu");
    run(1, OP_DIV,  32'd5, 32'd0, 32'd5, 32'hFF, 1, 1, "w8.div0");
    run(1, OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 0, 9, "w8.divu_9_3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
